display_scan_capture: RTL and testbench

//  Reader side of the 4-digit multiplexed 7-segment bus (ANOD active-low digit select, CAT segment byte).

---
 rtl/display_scan_capture_pkg.sv | 20 ++
 rtl/display_scan_capture_anode_decode.sv | 28 ++
 rtl/display_scan_capture.sv | 146 ++++++++++++++
 tb/tb_display_scan_capture.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_capture_pkg.sv
// Shared definitions for the 7-segment scan capture block: anode codes, FSM states, slot helpers.
package display_scan_capture_pkg;

    localparam logic [3:0] AnodBlank = 4'hF;
    localparam logic [3:0] AnodSlot0 = 4'b1110;
    localparam logic [3:0] AnodSlot1 = 4'b1101;
    localparam logic [3:0] AnodSlot2 = 4'b1011;
    localparam logic [3:0] AnodSlot3 = 4'b0111;

    typedef enum logic [1:0] {
        SIdle,
        SSettle,
        SHold
    } state_e;

    function automatic logic [3:0] slot_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/display_scan_capture_anode_decode.sv
// Classifies a registered anode sample as blank, a single valid digit slot, or an illegal overlap.
module display_scan_capture_anode_decode
    import display_scan_capture_pkg::*;
(
    input  logic [3:0] anod_i,
    output logic       blank_o,
    output logic       valid_o,
    output logic       illegal_o,
    output logic [1:0] idx_o
);

    always_comb begin
        blank_o   = 1'b0;
        valid_o   = 1'b0;
        illegal_o = 1'b0;
        idx_o     = 2'd0;
        unique case (anod_i)
            AnodBlank: blank_o = 1'b1;
            AnodSlot0: begin valid_o = 1'b1; idx_o = 2'd0; end
            AnodSlot1: begin valid_o = 1'b1; idx_o = 2'd1; end
            AnodSlot2: begin valid_o = 1'b1; idx_o = 2'd2; end
            AnodSlot3: begin valid_o = 1'b1; idx_o = 2'd3; end
            // Every remaining code has two or more digits selected at once.
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/display_scan_capture.sv
// Loopback monitor for the multiplexed 7-segment bus: qualifies each digit slot after a
// stability window and publishes a coherent 4-digit frame once all slots are captured.
module display_scan_capture
    import display_scan_capture_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ANOD,
    input  logic [7:0] CAT,
    output logic [7:0] digit0,
    output logic [7:0] digit1,
    output logic [7:0] digit2,
    output logic [7:0] digit3,
    output logic       frame_valid,
    output logic [3:0] seen_mask,
    output logic       err_multi,
    output logic       scan_lost
);

    localparam logic [CNT_W-1:0] SettleMax  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutMax = CNT_W'(TIMEOUT_CYCLES);

    logic [3:0]       anod_q, anod_prev_q;
    logic [7:0]       cat_q, cat_prev_q;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [CNT_W-1:0] to_q, to_d;
    state_e           state_q;
    logic [7:0]       shadow_q [4];
    logic [7:0]       digit_q  [4];
    logic [3:0]       seen_q, seen_upd;
    logic             fv_q, err_q, lost_q;

    logic       dec_blank, dec_valid, dec_illegal;
    logic [1:0] dec_idx;
    logic       changed, capture;

    display_scan_capture_anode_decode u_decode (
        .anod_i    (anod_q),
        .blank_o   (dec_blank),
        .valid_o   (dec_valid),
        .illegal_o (dec_illegal),
        .idx_o     (dec_idx)
    );

    always_comb begin
        changed = {anod_q, cat_q} != {anod_prev_q, cat_prev_q};
        if (changed) begin
            stab_d = '0;
        end else if (stab_q == SettleMax) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + CNT_W'(1);
        end
        // Only one capture per dwell: an unchanged pattern in SHold has already been taken.
        capture  = dec_valid && (changed || (state_q != SHold)) && (stab_d == SettleMax);
        seen_upd = seen_q | slot_onehot(dec_idx);
        if (capture) begin
            to_d = '0;
        end else if (to_q == TimeoutMax) begin
            to_d = to_q;
        end else begin
            to_d = to_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            anod_q      <= AnodBlank;
            cat_q       <= '0;
            anod_prev_q <= AnodBlank;
            cat_prev_q  <= '0;
            stab_q      <= '0;
            to_q        <= '0;
            state_q     <= SIdle;
            seen_q      <= '0;
            fv_q        <= 1'b0;
            err_q       <= 1'b0;
            lost_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                digit_q[i]  <= '0;
            end
        end else begin
            anod_q      <= ANOD;
            cat_q       <= CAT;
            anod_prev_q <= anod_q;
            cat_prev_q  <= cat_q;
            stab_q      <= stab_d;
            to_q        <= to_d;
            lost_q      <= (to_d == TimeoutMax);
            err_q       <= dec_illegal;
            fv_q        <= 1'b0;

            if (dec_illegal) begin
                state_q <= SIdle;
            end else begin
                case (state_q)
                    SIdle: begin
                        if (dec_valid) state_q <= capture ? SHold : SSettle;
                    end
                    SSettle: begin
                        if (dec_blank)    state_q <= SIdle;
                        else if (capture) state_q <= SHold;
                    end
                    SHold: begin
                        if (changed) begin
                            if (dec_blank) state_q <= SIdle;
                            else           state_q <= capture ? SHold : SSettle;
                        end
                    end
                    default: state_q <= SIdle;
                endcase
            end

            if (capture) begin
                shadow_q[dec_idx] <= cat_q;
                if (seen_upd == 4'hF) begin
                    for (int i = 0; i < 4; i++) begin
                        digit_q[i] <= (2'(i) == dec_idx) ? cat_q : shadow_q[i];
                    end
                    fv_q   <= 1'b1;
                    seen_q <= '0;
                end else begin
                    seen_q <= seen_upd;
                end
            end else if ((to_d == TimeoutMax) && (to_q != TimeoutMax)) begin
                // Scan lost: drop the partial frame, keep the last published digits.
                seen_q <= '0;
            end
        end
    end

    assign digit0      = digit_q[0];
    assign digit1      = digit_q[1];
    assign digit2      = digit_q[2];
    assign digit3      = digit_q[3];
    assign frame_valid = fv_q;
    assign seen_mask   = seen_q;
    assign err_multi   = err_q;
    assign scan_lost   = lost_q;

endmodule

// File: tb/tb_display_scan_capture.sv
// Self-checking bench for display_scan_capture: table-driven frame, directed corner sequences,
// and randomized scan traffic checked every cycle against a run-length reference model.
module tb_display_scan_capture;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] ANOD = 4'hF;
    logic [7:0] CAT = 8'h00;
    logic [7:0] digit0, digit1, digit2, digit3;
    logic       frame_valid, err_multi, scan_lost;
    logic [3:0] seen_mask;

    display_scan_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (11)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ANOD        (ANOD),
        .CAT         (CAT),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .frame_valid (frame_valid),
        .seen_mask   (seen_mask),
        .err_multi   (err_multi),
        .scan_lost   (scan_lost)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int fv_count = 0;
    int err_count = 0;

    // Reference model: a slot is captured when its exact {anode,cat} pattern has been present
    // in the input register for exactly SETTLE consecutive cycles.
    logic [3:0]  m_aq;
    logic [7:0]  m_cq;
    logic [11:0] m_prev;
    int          m_run;
    int          m_to;
    logic [7:0]  m_sh  [4];
    logic [7:0]  m_dig [4];
    logic [3:0]  m_seen;
    logic        m_fv, m_err, m_lost;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] a, input logic [7:0] c, input logic rst_n);
        int zeros;
        int idx;
        if (!rst_n) begin
            m_aq = 4'hF; m_cq = 8'h00; m_prev = {4'hF, 8'h00}; m_run = 1; m_to = 0;
            m_seen = 4'h0; m_fv = 1'b0; m_err = 1'b0; m_lost = 1'b0;
            for (int i = 0; i < 4; i++) begin m_sh[i] = 8'h00; m_dig[i] = 8'h00; end
            return;
        end
        if ({m_aq, m_cq} != m_prev) m_run = 1;
        else if (m_run < 100000)    m_run++;
        m_prev = {m_aq, m_cq};
        zeros = $countones(~m_aq);
        idx = 0;
        for (int i = 0; i < 4; i++) if (!m_aq[i]) idx = i;
        m_fv  = 1'b0;
        m_err = (zeros > 1);
        if (zeros == 1 && m_run == SETTLE) begin
            m_sh[idx] = m_cq;
            m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) begin
                for (int i = 0; i < 4; i++) m_dig[i] = m_sh[i];
                m_fv = 1'b1;
                m_seen = 4'h0;
            end
            m_to = 0;
        end else if (m_to < TIMEOUT) begin
            m_to++;
            if (m_to == TIMEOUT) m_seen = 4'h0;
        end
        m_lost = (m_to == TIMEOUT);
        m_aq = a;
        m_cq = c;
    endtask

    task automatic tick(input logic [3:0] a, input logic [7:0] c);
        ANOD = a;
        CAT  = c;
        @(posedge clk);
        model_step(a, c, reset);
        #1;
        chk("digit0", 32'(digit0), 32'(m_dig[0]));
        chk("digit1", 32'(digit1), 32'(m_dig[1]));
        chk("digit2", 32'(digit2), 32'(m_dig[2]));
        chk("digit3", 32'(digit3), 32'(m_dig[3]));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("seen_mask", 32'(seen_mask), 32'(m_seen));
        chk("err_multi", 32'(err_multi), 32'(m_err));
        chk("scan_lost", 32'(scan_lost), 32'(m_lost));
        if (frame_valid) fv_count++;
        if (err_multi)   err_count++;
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) tick(a, c);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        hold(4'hF, 8'h00, 2);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0] anod;
        logic [7:0] cat;
        int         cycles;
        logic [3:0] exp_seen;
        int         exp_frames;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int fv0, er0, first_lost;
        logic [3:0] codes [4];
        logic [3:0] a;
        logic [7:0] c;

        codes[0] = 4'b1110; codes[1] = 4'b1101; codes[2] = 4'b1011; codes[3] = 4'b0111;
        tbl[0] = '{anod: 4'b1110, cat: 8'hC0, cycles: 10, exp_seen: 4'h1, exp_frames: 0};
        tbl[1] = '{anod: 4'b1101, cat: 8'hF9, cycles: 10, exp_seen: 4'h3, exp_frames: 0};
        tbl[2] = '{anod: 4'b1011, cat: 8'hA4, cycles: 10, exp_seen: 4'h7, exp_frames: 0};
        tbl[3] = '{anod: 4'b0111, cat: 8'hB0, cycles: 10, exp_seen: 4'h0, exp_frames: 1};

        do_reset();
        chk("reset_seen", 32'(seen_mask), 32'h0);
        chk("reset_digits", {digit3, digit2, digit1, digit0}, 32'h0);

        // Full scan, one slot per table row.
        fv_count = 0;
        for (int i = 0; i < 4; i++) begin
            hold(tbl[i].anod, tbl[i].cat, tbl[i].cycles);
            chk("tbl_seen", 32'(seen_mask), 32'(tbl[i].exp_seen));
            chk("tbl_frames", 32'(fv_count), 32'(tbl[i].exp_frames));
        end
        chk("frame_digits", {digit3, digit2, digit1, digit0}, 32'hB0A4F9C0);

        // Timeout: last capture was on the 5th slot-3 edge, so to_cnt hits 1024 on blank tick 1019.
        first_lost = -1;
        for (int i = 1; i <= 1100; i++) begin
            tick(4'hF, 8'h00);
            if (scan_lost && first_lost < 0) first_lost = i;
        end
        chk("lost_cycle", 32'(first_lost), 32'd1019);
        chk("lost_digits_held", {digit3, digit2, digit1, digit0}, 32'hB0A4F9C0);
        hold(4'b1110, 8'h11, 6);
        chk("lost_cleared", 32'(scan_lost), 32'h0);
        chk("lost_new_seen", 32'(seen_mask), 32'h1);

        // Slot 1 too short to settle, slot 2 settles.
        do_reset();
        hold(4'b1101, 8'hF9, 2);
        hold(4'b1011, 8'hA4, 6);
        chk("short_dwell_seen", 32'(seen_mask), 32'h4);

        // One-cycle overlap of two anodes.
        er0 = err_count;
        tick(4'b1100, 8'h55);
        hold(4'hF, 8'h00, 3);
        chk("err_pulses", 32'(err_count - er0), 32'd1);
        chk("err_seen_kept", 32'(seen_mask), 32'h4);

        // Segment byte changes while slot 0 stays selected: the later byte wins.
        do_reset();
        fv0 = fv_count;
        hold(4'b1110, 8'h92, 6);
        hold(4'b1110, 8'h82, 6);
        chk("recap_seen", 32'(seen_mask), 32'h1);
        hold(4'b1101, 8'h01, 6);
        hold(4'b1011, 8'h02, 6);
        hold(4'b0111, 8'h03, 6);
        chk("recap_frames", 32'(fv_count - fv0), 32'd1);
        chk("recap_digit0", 32'(digit0), 32'h82);

        // Reset with three slots captured discards everything.
        hold(4'b1110, 8'h10, 6);
        hold(4'b1101, 8'h20, 6);
        hold(4'b1011, 8'h30, 6);
        chk("pre_reset_seen", 32'(seen_mask), 32'h7);
        reset = 1'b0;
        tick(4'hF, 8'h00);
        reset = 1'b1;
        chk("midreset_out", {digit3, digit2, digit1, digit0}, 32'h0);
        chk("midreset_seen", 32'(seen_mask), 32'h0);
        fv0 = fv_count;
        hold(4'b0111, 8'h40, 6);
        chk("midreset_no_frame", 32'(fv_count - fv0), 32'd0);
        chk("midreset_seen3", 32'(seen_mask), 32'h8);

        // Randomized scan traffic with occasional overlaps, blanks and resets.
        for (int seg = 0; seg < 600; seg++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 15)       a = codes[$urandom_range(0, 3)];
            else if (r < 18)  a = 4'hF;
            else              a = 4'($urandom_range(0, 15));
            c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                tick(a, c);
                reset = 1'b1;
            end
            hold(a, c, int'($urandom_range(1, 8)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
